// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential divider.
package alu_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] rem,
  input  logic [WIDTH:0] dvs,
  input  logic           nbit,
  output logic [WIDTH:0] rem_nxt,
  output logic           qbit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One extra bit above the remainder width keeps the borrow visible.
  always_comb begin
    shifted = {rem, nbit};
    diff    = shifted - {1'b0, dvs};
    qbit    = ~diff[WIDTH+1];
    rem_nxt = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock.
// Signed operation is built only when SEQ_DIV_SIGNED_EN is defined.
module seq_div
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DivZero,
  output logic             V
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             qbit;
  logic             dz;
  logic             load;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  assign load = Start & ((state == IDLE) | (state == FIN));

`ifdef SEQ_DIV_SIGNED_EN
  logic             a_neg;
  logic             b_neg;
  logic             ovf;
  logic             ov_r;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] a_raw;

  // Operands are divided as magnitudes; signs are reapplied after the last step.
  always_comb begin
    a_neg = Signed & A[WIDTH-1];
    b_neg = Signed & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
    ovf   = Signed & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
  end

  always_comb begin
    q_res = neg_q ? -dvd : dvd;
    r_res = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (dz) begin
      q_res = '1;
      r_res = a_raw;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = Signed;
  assign a_mag         = A;
  assign b_mag         = B;
  assign q_res         = dvd;
  assign r_res         = rem[WIDTH-1:0];
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvs     ({1'b0, dvs}),
    .nbit    (dvd[WIDTH-1]),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // Control FSM and datapath; quotient bits shift into the dividend register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      dz      <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Q       <= '0;
      R       <= '0;
      DivZero <= 1'b0;
      V       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      ov_r    <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      a_raw   <= '0;
`endif
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: ;
        RUN: begin
          rem <= rem_nxt;
          dvd <= {dvd[WIDTH-2:0], qbit};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIN;
        end
        FIN: begin
          Q       <= q_res;
          R       <= r_res;
          DivZero <= dz;
`ifdef SEQ_DIV_SIGNED_EN
          V       <= ov_r;
`else
          V       <= 1'b0;
`endif
          Done    <= 1'b1;
          Busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A Start taken in FIN overrides the return to IDLE on the same edge.
      if (load) begin
        state <= RUN;
        Busy  <= 1'b1;
        cnt   <= '0;
        rem   <= '0;
        dvd   <= a_mag;
        dvs   <= b_mag;
        dz    <= (B == '0);
`ifdef SEQ_DIV_SIGNED_EN
        ov_r  <= ovf;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        a_raw <= A;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed table, multi-cycle corner sequences, random vs model.
module tb_seq_div;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;
`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         Start;
  logic         Signed;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         DivZero;
  logic         V;

  int errors = 0;
  int checks = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Start   (Start),
    .Signed  (Signed),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Q       (Q),
    .R       (R),
    .DivZero (DivZero),
    .V       (V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sg;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         v;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division with the documented special cases.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic v);
    longint sa, sb;
    dz = (b == '0);
    v  = 1'b0;
    if (dz) begin
      q = '1;
      r = a;
    end else if (!(sg && SG)) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
      v = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output logic v);
    A = a; B = b; Signed = sg; Start = 1'b1;
    step();
    Start = 1'b0; A = $urandom; B = $urandom; Signed = 1'($urandom_range(0, 1));
    chk1("busy_after_start", Busy, 1'b1);
    lat = 0;
    while (!Done && lat < 100) begin
      step();
      lat++;
    end
    chk1("done_seen", Done, 1'b1);
    chk1("busy_low_at_done", Busy, 1'b0);
    q = Q; r = R; dz = DivZero; v = V;
  endtask

  int           lat;
  int           ndone;
  logic [W-1:0] gq, gr, eq, er;
  logic         gdz, gv, edz, ev;
  logic [W-1:0] ra, rb;
  logic         rsg;

  initial begin
    tbl[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0};
    tbl[1]  = '{32'hFFFFFF9C, 32'd7,        1'b1, SG ? 32'hFFFFFFF2 : 32'h24924916,
                                                  SG ? 32'hFFFFFFFE : 32'd2,   1'b0, 1'b0};
    tbl[2]  = '{32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0};
    tbl[3]  = '{32'h1234,     32'd0,        1'b1, 32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0};
    tbl[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, SG ? 32'h80000000 : 32'd0,
                                                  SG ? 32'd0 : 32'h80000000,  1'b0, SG};
    tbl[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0};
    tbl[6]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0};
    tbl[7]  = '{32'd7,        32'd100,      1'b0, 32'd0,        32'd7,        1'b0, 1'b0};
    tbl[8]  = '{32'd100,      32'hFFFFFFF9, 1'b1, SG ? 32'hFFFFFFF2 : 32'd0,
                                                  SG ? 32'd2 : 32'd100,       1'b0, 1'b0};
    tbl[9]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, SG ? 32'd14 : 32'd0,
                                                  SG ? 32'hFFFFFFFE : 32'hFFFFFF9C, 1'b0, 1'b0};
    tbl[10] = '{32'hFFFFFF9C, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 1'b0};

    rst_n = 1'b0; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
    repeat (3) step();
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    chkw("rst_q", Q, '0);
    chkw("rst_r", R, '0);
    chk1("rst_dz", DivZero, 1'b0);
    chk1("rst_v", V, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sg, lat, gq, gr, gdz, gv);
      chkn($sformatf("vec%0d_latency", i), lat, LAT);
      chkw($sformatf("vec%0d_q", i), gq, tbl[i].q);
      chkw($sformatf("vec%0d_r", i), gr, tbl[i].r);
      chk1($sformatf("vec%0d_dz", i), gdz, tbl[i].dz);
      chk1($sformatf("vec%0d_v", i), gv, tbl[i].v);
    end

    // Results persist and Done stays a single pulse.
    repeat (3) step();
    chk1("hold_done_low", Done, 1'b0);
    chk1("hold_busy_low", Busy, 1'b0);
    chkw("hold_q", Q, tbl[NV-1].q);
    chkw("hold_r", R, tbl[NV-1].r);
    chk1("hold_dz", DivZero, tbl[NV-1].dz);

    // Start re-pulsed while running is ignored.
    A = 32'd100; B = 32'd7; Signed = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (5) step();
    A = 32'd1000; B = 32'd3; Start = 1'b1;
    step();
    Start = 1'b0;
    lat = 6;
    while (!Done && lat < 100) begin
      step();
      lat++;
    end
    chkn("midrun_latency", lat, LAT);
    chkw("midrun_q", Q, 32'd14);
    chkw("midrun_r", R, 32'd2);
    step();

    // Back-to-back: Start held on the edge that produces Done.
    A = 32'd100; B = 32'd7; Signed = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (LAT - 1) step();
    chk1("b2b_no_early_done", Done, 1'b0);
    A = 32'd1000; B = 32'd3; Start = 1'b1;
    step();
    Start = 1'b0;
    chk1("b2b_first_done", Done, 1'b1);
    chkw("b2b_first_q", Q, 32'd14);
    chkw("b2b_first_r", R, 32'd2);
    chk1("b2b_busy_kept", Busy, 1'b1);
    lat = 0;
    step();
    lat++;
    while (!Done && lat < 100) begin
      step();
      lat++;
    end
    chkn("b2b_second_latency", lat, LAT);
    chkw("b2b_second_q", Q, 32'd333);
    chkw("b2b_second_r", R, 32'd1);

    // Reset after ten iterations aborts; Start during reset is ignored.
    step();
    A = 32'd100; B = 32'd7; Signed = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (10) step();
    rst_n = 1'b0; Start = 1'b1; A = 32'd5; B = 32'd1;
    step();
    rst_n = 1'b1; Start = 1'b0;
    chk1("abort_busy", Busy, 1'b0);
    chk1("abort_done", Done, 1'b0);
    chkw("abort_q", Q, '0);
    chkw("abort_r", R, '0);
    chk1("abort_dz", DivZero, 1'b0);
    chk1("abort_v", V, 1'b0);
    ndone = 0;
    repeat (40) begin
      step();
      if (Done) ndone++;
    end
    chkn("abort_no_done", ndone, 0);
    run_op(32'd100, 32'd7, 1'b0, lat, gq, gr, gdz, gv);
    chkn("after_abort_latency", lat, LAT);
    chkw("after_abort_q", gq, 32'd14);
    chkw("after_abort_r", gr, 32'd2);

    // Random operands against the reference model.
    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 32'd1;
        3:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rsg = 1'($urandom_range(0, 1));
      model(ra, rb, rsg, eq, er, edz, ev);
      run_op(ra, rb, rsg, lat, gq, gr, gdz, gv);
      chkn($sformatf("rnd%0d_latency", n), lat, LAT);
      chkw($sformatf("rnd%0d_q a=%h b=%h s=%b", n, ra, rb, rsg), gq, eq);
      chkw($sformatf("rnd%0d_r a=%h b=%h s=%b", n, ra, rb, rsg), gr, er);
      chk1($sformatf("rnd%0d_dz", n), gdz, edz);
      chk1($sformatf("rnd%0d_v", n), gv, ev);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
